alu_stream: RTL and testbench
=============================

ALU_STREAM -- requirements
Module: alu_stream

Interface — parameters
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter VERSION, default 1, selecting the operation: 1 passes a, 2 passes b, 3 computes a+b, 4 accumulates a per channel.
REQ-003 The block SHALL have parameter NCHAN, default 2, giving the number of logical channels (legal range 1..16); CW = max(1, clog2(NCHAN)).

Interface — ports
REQ-004 clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n, input, 1: reset; asynchronous assertion, active-low.
REQ-006 in_valid, input, 1: an input beat is present.
REQ-007 in_ready, output, 1: the block can accept a beat.
REQ-008 in_chan, input, CW: the channel tag of the beat.
REQ-009 in_a and in_b, input, WIDTH each: the operands.
REQ-010 acc_clear, input, 1: synchronous clear of all accumulators.
REQ-011 out_valid, output, 1: a result is present.
REQ-012 out_ready, input, 1: downstream accepts the result.
REQ-013 out_chan, output, CW: the channel tag of the result.
REQ-014 out_data, output, WIDTH: the result.
REQ-015 out_carry, output, 1: carry-out of the operation.
REQ-016 out_err, output, 1: the beat's in_chan was >= NCHAN.

Function
REQ-017 An input beat SHALL be accepted on a rising edge where in_valid && in_ready; a result SHALL be retired on a rising edge where out_valid && out_ready.
REQ-018 Accepted beats SHALL enter a 2-entry in-order result FIFO; in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries.
REQ-019 When the FIFO is full, a same-cycle retire SHALL NOT raise in_ready in that cycle; in_ready is registered and has no combinational path from out_ready.
REQ-020 The latency from acceptance to out_valid SHALL be 1 cycle when the FIFO was empty; no bubble is allowed.
REQ-021 out_valid, out_chan, out_data, out_carry and out_err SHALL be driven from the FIFO head.
REQ-022 While out_valid=1 and out_ready=0, all of these outputs SHALL hold stable.
REQ-023 A simultaneous push and pop with 1 entry occupied SHALL leave the occupancy at 1.
REQ-024 A simultaneous push and pop with 0 entries occupied is impossible, because out_valid=0 when the FIFO is empty.
REQ-025 VERSION 1 SHALL produce out_data = a and out_carry = 0.
REQ-026 VERSION 2 SHALL produce out_data = b and out_carry = 0.
REQ-027 VERSION 3 SHALL produce {out_carry, out_data} = a + b, computed at WIDTH+1 bits.
REQ-028 VERSION 4 SHALL, for each accepted beat, update acc[in_chan] to (acc[in_chan] + a) mod 2^WIDTH.
REQ-029 VERSION 4 SHALL set out_data to the new acc value and out_carry to the carry of that addition; the value wraps around rather than saturating.
REQ-030 In VERSION 4, acc_clear SHALL zero every accumulator; if a beat is accepted in the same cycle, it SHALL see acc = 0, so its result is out_data = a, out_carry = 0, and acc[in_chan] is left holding a.
REQ-031 In VERSIONs 1–3, acc_clear SHALL have no effect.
REQ-032 A beat with in_chan >= NCHAN SHALL be accepted, flagged out_err = 1 and given out_data = 0 and out_carry = 0; in VERSION 4 it SHALL leave all accumulators unchanged.
REQ-033 VERSION values other than 1–4 SHALL be rejected at elaboration.
REQ-034 Only storage that the selected VERSION uses SHALL be generated; accumulators exist only when VERSION = 4.

Reset
REQ-035 While rst_n=0, the FIFO SHALL be empty.
REQ-036 While rst_n=0, out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-037 While rst_n=0, out_chan, out_data, out_carry and out_err SHALL be 0.
REQ-038 While rst_n=0, all accumulators SHALL be 0.
REQ-039 On the first rising edge after rst_n deasserts, in_ready SHALL become 1.
REQ-040 A reset asserted mid-stream SHALL discard all FIFO entries and accumulator contents immediately, without waiting for a clock edge.

Verification
REQ-041 VERSION=3, WIDTH=4: accept a=9, b=8, chan=1 → next cycle out_valid=1, out_data=1, out_carry=1, out_chan=1, out_err=0.
REQ-042 VERSION=4, NCHAN=2: accept chan0 a=15, then chan0 a=2, then chan1 a=3 → results in order: (15, carry 0); (1, carry 1); (3, carry 0).
REQ-043 Backpressure: hold out_ready=0 and push 3 beats → only 2 accepted and in_ready=0. Then assert out_ready for one cycle → exactly one retire, and the outputs held stable throughout the stall.
REQ-044 VERSION=4, acc0=5: acc_clear=1 in the same cycle as accepting chan0 a=4 → result 4; the following chan0 beat a=1 → result 5.
REQ-045 NCHAN=3: accept in_chan=3 → out_err=1, out_data=0, out_carry=0, and all accumulators unchanged.
REQ-046 Assert rst_n=0 with 2 entries queued → out_valid=0 and in_ready=0 immediately; after release, the first beat accumulates from 0.

Source files
------------

// File: rtl/alu_stream.sv
`default_nettype none
// ============================================================================
// Module   : alu_stream
// Purpose  : Per-beat ALU (pass a / pass b / add / per-channel accumulate)
//            feeding a 2-entry in-order result FIFO with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module alu_stream #(
    parameter int WIDTH   = 4,
    parameter int VERSION = 1,
    parameter int NCHAN   = 2,
    localparam int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_chan,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_err
);

    logic                  push;
    logic                  pop;
    logic                  chan_ok;
    logic [WIDTH-1:0]      res_data;
    logic                  res_carry;

    logic [1:0]            count_q, count_d;
    logic                  in_ready_q, in_ready_d;
    logic [1:0][WIDTH-1:0] data_q, data_d;
    logic [1:0][CW-1:0]    chan_q, chan_d;
    logic [1:0]            carry_q, carry_d;
    logic [1:0]            err_q, err_d;

    assign chan_ok   = (32'(in_chan) < NCHAN);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    assign in_ready  = in_ready_q;
    assign out_chan  = chan_q[0];
    assign out_data  = data_q[0];
    assign out_carry = carry_q[0];
    assign out_err   = err_q[0];

    generate
        if (VERSION == 1) begin : g_pass_a
            assign res_data  = chan_ok ? in_a : '0;
            assign res_carry = 1'b0;
        end else if (VERSION == 2) begin : g_pass_b
            assign res_data  = chan_ok ? in_b : '0;
            assign res_carry = 1'b0;
        end else if (VERSION == 3) begin : g_add
            logic [WIDTH:0] sum;
            assign sum       = {1'b0, in_a} + {1'b0, in_b};
            assign res_data  = chan_ok ? sum[WIDTH-1:0] : '0;
            assign res_carry = chan_ok & sum[WIDTH];
        end else if (VERSION == 4) begin : g_acc
            logic [NCHAN-1:0][WIDTH-1:0] acc_q, acc_d;
            logic [CW-1:0]               idx;
            logic [WIDTH-1:0]            base;
            logic [WIDTH:0]              sum;

            // A clear in the same cycle as a beat makes the beat start from zero.
            assign idx       = chan_ok ? in_chan : '0;
            assign base      = acc_clear ? '0 : acc_q[idx];
            assign sum       = {1'b0, base} + {1'b0, in_a};
            assign res_data  = chan_ok ? sum[WIDTH-1:0] : '0;
            assign res_carry = chan_ok & sum[WIDTH];

            always_comb begin
                acc_d = acc_clear ? '0 : acc_q;
                if (push && chan_ok) begin
                    acc_d[idx] = sum[WIDTH-1:0];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end else begin : g_bad_version
            $error("alu_stream: VERSION must be 1..4");
        end
    endgenerate

    // Entry 0 is the head; a pop shifts entry 1 down and a push lands in the
    // first slot that is free after that shift.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        carry_d = carry_q;
        err_d   = err_q;
        if (pop) begin
            data_d[0]  = data_q[1];
            chan_d[0]  = chan_q[1];
            carry_d[0] = carry_q[1];
            err_d[0]   = err_q[1];
        end
        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                data_d[0]  = res_data;
                chan_d[0]  = in_chan;
                carry_d[0] = res_carry;
                err_d[0]   = ~chan_ok;
            end else begin
                data_d[1]  = res_data;
                chan_d[1]  = in_chan;
                carry_d[1] = res_carry;
                err_d[1]   = ~chan_ok;
            end
        end
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            data_q     <= '0;
            chan_q     <= '0;
            carry_q    <= '0;
            err_q      <= '0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_stream
// Purpose  : Scoreboard bench running all four VERSIONs side by side (WIDTH=4, NCHAN=3).
// Revision : 1.0
// ============================================================================
module tb_alu_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_chan = '0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       acc_clear = 1'b0;
    logic       out_ready = 1'b0;

    wire [3:0]      ir, ov, ocar, oerr;
    wire [3:0][1:0] och;
    wire [3:0][3:0] od;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_dut
            alu_stream #(.WIDTH(4), .VERSION(k + 1), .NCHAN(3)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (ir[k]),
                .in_chan   (in_chan),
                .in_a      (in_a),
                .in_b      (in_b),
                .acc_clear (acc_clear),
                .out_valid (ov[k]),
                .out_ready (out_ready),
                .out_chan  (och[k]),
                .out_data  (od[k]),
                .out_carry (ocar[k]),
                .out_err   (oerr[k])
            );
        end
    endgenerate

    typedef struct packed {
        logic [1:0]      chan;
        logic            err;
        logic [3:0][3:0] d;
        logic [3:0]      c;
    } exp_t;

    exp_t       q[$];
    logic [3:0] macc [3];
    logic       mready = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] ch, input logic [3:0] a,
                        input logic [3:0] b, input logic clr, input logic ordy);
        exp_t       e;
        logic [4:0] s;
        logic       acc;
        in_valid = v; in_chan = ch; in_a = a; in_b = b; acc_clear = clr; out_ready = ordy;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("v%0d in_ready", k + 1), 8'(ir[k]), 8'(mready));
            chk($sformatf("v%0d out_valid", k + 1), 8'(ov[k]), 8'(q.size() != 0));
            if (q.size() != 0) begin
                chk($sformatf("v%0d out_chan", k + 1), 8'(och[k]), 8'(q[0].chan));
                chk($sformatf("v%0d out_data", k + 1), 8'(od[k]), 8'(q[0].d[k]));
                chk($sformatf("v%0d out_carry", k + 1), 8'(ocar[k]), 8'(q[0].c[k]));
                chk($sformatf("v%0d out_err", k + 1), 8'(oerr[k]), 8'(q[0].err));
            end
        end
        acc = v && mready;
        if (ordy && (q.size() != 0)) void'(q.pop_front());
        if (clr) for (int i = 0; i < 3; i++) macc[i] = 4'd0;
        if (acc) begin
            e = '0;
            e.chan = ch;
            e.err  = (ch >= 2'd3);
            if (!e.err) begin
                e.d[0] = a;
                e.d[1] = b;
                s = {1'b0, a} + {1'b0, b};
                e.d[2] = s[3:0]; e.c[2] = s[4];
                s = {1'b0, macc[ch]} + {1'b0, a};
                macc[ch] = s[3:0];
                e.d[3] = s[3:0]; e.c[3] = s[4];
            end
            q.push_back(e);
        end
        mready = (q.size() < 2);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        for (int i = 0; i < 3; i++) macc[i] = 4'd0;
        mready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("v%0d rst in_ready", k + 1), 8'(ir[k]), 8'd0);
            chk($sformatf("v%0d rst out_valid", k + 1), 8'(ov[k]), 8'd0);
            chk($sformatf("v%0d rst out_chan", k + 1), 8'(och[k]), 8'd0);
            chk($sformatf("v%0d rst out_data", k + 1), 8'(od[k]), 8'd0);
            chk($sformatf("v%0d rst out_carry", k + 1), 8'(ocar[k]), 8'd0);
            chk($sformatf("v%0d rst out_err", k + 1), 8'(oerr[k]), 8'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("in_ready before first edge", 8'(ir), 8'h0);
        @(posedge clk);
        #1;
        mready = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        step(0, 0, 0, 0, 0, 1);

        // 9 + 8 on channel 1: sum 1 with carry
        step(1, 1, 4'd9, 4'd8, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // accumulate 15, then 2 (wraps to 1 with carry), then 3 on channel 1
        step(1, 0, 4'd15, 4'd1, 0, 1);
        step(1, 0, 4'd2, 4'd7, 0, 1);
        step(1, 1, 4'd3, 4'd13, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // backpressure: three offers, only two accepted, then a single retire
        step(1, 2, 4'd1, 4'd2, 0, 0);
        step(1, 0, 4'd3, 4'd4, 0, 0);
        step(1, 1, 4'd5, 4'd6, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // clear with a concurrent beat sees zero
        step(1, 0, 4'd5, 4'd0, 1, 1);
        step(1, 0, 4'd4, 4'd0, 1, 1);
        step(1, 0, 4'd1, 4'd0, 0, 1);

        // out-of-range channel: flagged, zero result, accumulators untouched
        step(1, 3, 4'd9, 4'd9, 0, 1);
        step(1, 0, 4'd0, 4'd0, 0, 1);
        step(1, 1, 4'd0, 4'd0, 0, 1);
        step(1, 2, 4'd0, 4'd0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // mid-stream reset with two entries queued
        step(1, 0, 4'd6, 4'd1, 0, 0);
        step(1, 1, 4'd8, 4'd2, 0, 0);
        do_reset();
        step(1, 0, 4'd7, 4'd3, 0, 1);
        step(1, 1, 4'd2, 4'd4, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                 4'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
